output_memory_node: RTL and testbench
=====================================

// Module: output_memory_node
// PURPOSE
//  Downstream counterpart of the CGRA input memory nodes. Buffers the result stream leaving an
//  output data mover (ODM) in a FIFO, then writes each word to memory over an OBI master port.
//  Addresses are base + offset; the offset advances by a configurable byte stride.
//  done_o asserts once every granted write has received its response.
// PARAMETERS
//  FIFO_DEPTH       4  words buffered between the ODM and OBI; power of two, >= 2
//  MAX_OUTSTANDING  4  granted writes allowed without an rvalid; >= 1
// PORTS
//  clk_i            in   1    clock
//  rst_ni           in   1    asynchronous active-low reset
//  clr_i            in   1    synchronous clear: state, counters and FIFO
//  exec_i           in   1    execution phase active
//  output_addr_i    in   32   base byte address
//  output_size_i    in   16   transfer size in bytes (offset limit)
//  output_stride_i  in   16   byte increment per word
//  masters_req_o    out  obi  OBI request (req, we, be, addr, wdata)
//  masters_resp_i   in   obi  OBI response (gnt, rvalid; rdata ignored)
//  din_i            in   32   result word from the ODM
//  din_v_i          in   1    din_i valid
//  din_r_o          out  1    ready to the ODM
//  done_o           out  1    all writes issued and acknowledged
// BEHAVIOUR
//  Reset / clr_i: state=S_IDLE, offset=0, outstanding=0, FIFO empty.
//   Outputs after reset/clear: req=0, done_o=0, din_r_o=0 (din_r_o also needs exec_i).
//   clr_i has priority over every other event in the same cycle.
//  Fixed OBI fields: we=1, be=4'b1111.
//   addr  = output_addr_i + {16'h0, offset} (32-bit, wraps).
//   wdata = FIFO head.
//  Event definitions:
//   transaction = req & gnt.
//   n_offset = {1'b0,offset} + {1'b0,output_stride_i}, 17 bits; offset takes n_offset[15:0].
//  Outstanding counter:
//   +1 on transaction, -1 on rvalid; both in the same cycle leaves it unchanged.
//   rvalid with count 0 is an assertion error.
//  Input side:
//   push = din_v_i & din_r_o & state in {S_IDLE, S_WRITE}.
//   din_r_o = exec_i & !full in S_IDLE/S_WRITE; din_r_o = exec_i in S_DRAIN/S_DONE.
//   Words arriving in S_DRAIN/S_DONE are accepted and discarded, so the ODM never stalls.
//  FIFO is not fall-through: a word accepted at cycle N can be requested at N+1 at the earliest.
//  States:
//   S_IDLE:
//    exec_i & size!=0 -> S_WRITE.
//    exec_i & size==0 -> S_DONE.
//    otherwise stay in S_IDLE.
//   S_WRITE:
//    req = !empty & (outstanding < MAX_OUTSTANDING).
//    On a transaction: pop the FIFO, offset <= n_offset.
//    transaction & (n_offset >= {1'b0,size}) -> S_DRAIN (last word issued).
//   S_DRAIN:
//    req=0.
//    Go to S_DONE in the cycle after outstanding reaches 0 (registered compare).
//   S_DONE:
//    done_o=1, req=0.
//    Terminal state; left only via clr_i or rst_ni.
//  Boundary conditions:
//   - FIFO full: din_r_o=0; nothing is dropped in S_WRITE.
//   - FIFO empty in S_WRITE: req=0.
//   - req stays asserted with stable addr/wdata until gnt (OBI rule).
//   - stride=0 with size>0 never terminates; the configuration must avoid it (bench asserts).
//   - A push and a pop in the same cycle leave the FIFO level unchanged.
//   - Config inputs must stay stable from S_IDLE exit until done_o.
// TESTING
//  T1 base=0x1000, size=16, stride=4; 4 words; gnt same cycle, rvalid +1
//     -> writes to 0x1000/04/08/0C with matching wdata; done_o 2 cycles after the last rvalid.
//  T2 size=0, exec_i=1 -> S_DONE next cycle, done_o=1, no req ever asserted.
//  T3 FIFO_DEPTH=4, gnt held low 10 cycles, din_v_i=1 continuously
//     -> din_r_o drops after 4 pushes; order preserved once gnt resumes.
//  T4 MAX_OUTSTANDING=2, rvalid delayed 5 cycles
//     -> req deasserts after 2 grants; resumes after the first rvalid.
//  T5 size=8, stride=4, 3 words sent -> third word discarded, only 2 writes issued, done_o=1.
//  T6 clr_i mid-S_WRITE with 2 words buffered
//     -> next cycle S_IDLE, req=0, FIFO empty, offset 0; rerun from 0x1000 succeeds.

Source files
------------

// File: rtl/output_memory_node.sv
// Output memory node: buffers the ODM result stream in a small FIFO and writes each word to
// memory over an OBI master port at base + offset, with the offset advancing by a byte stride.
module output_memory_node #(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        exec_i,
    input  logic [31:0] output_addr_i,
    input  logic [15:0] output_size_i,
    input  logic [15:0] output_stride_i,
    // OBI request  {req, we, be[3:0], addr[31:0], wdata[31:0]}
    output logic [69:0] masters_req_o,
    // OBI response {gnt, rvalid, rdata[31:0]}
    input  logic [33:0] masters_resp_i,
    input  logic [31:0] din_i,
    input  logic        din_v_i,
    output logic        din_r_o,
    output logic        done_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [31:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    logic [OW-1:0] outstanding_q;
    logic [15:0]   offset_q;
    logic [16:0]   n_offset;
    logic          full, empty, push, pop;
    logic          req, gnt, rvalid, trans;
    logic [31:0]   unused_rdata;

    assign gnt          = masters_resp_i[33];
    assign rvalid       = masters_resp_i[32];
    assign unused_rdata = masters_resp_i[31:0];

    assign full     = (count_q == (PW + 1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign n_offset = {1'b0, offset_q} + {1'b0, output_stride_i};
    assign trans    = req & gnt;
    assign pop      = trans;
    // Words accepted after the last write was issued are swallowed, not buffered.
    assign push     = din_v_i & din_r_o & ((state_q == S_IDLE) || (state_q == S_WRITE));

    assign masters_req_o = {req, 1'b1, 4'b1111, output_addr_i + {16'h0, offset_q}, mem[rptr_q]};

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        din_r_o = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                din_r_o = exec_i & ~full;
                if (exec_i) begin
                    state_d = (output_size_i != 16'h0) ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                din_r_o = exec_i & ~full;
                req     = ~empty & (outstanding_q < OW'(MAX_OUTSTANDING));
                if (req && gnt && (n_offset >= {1'b0, output_size_i})) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                din_r_o = exec_i;
                if (outstanding_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                din_r_o = exec_i;
                done_o  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            offset_q      <= '0;
        end else if (clr_i) begin
            state_q       <= S_IDLE;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            offset_q      <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q   <= rptr_q + PW'(1);
                offset_q <= n_offset[15:0];
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
            unique case ({trans, rvalid})
                2'b10:   outstanding_q <= outstanding_q + OW'(1);
                2'b01:   outstanding_q <= outstanding_q - OW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push && !clr_i) begin
            mem[wptr_q] <= din_i;
        end
    end

`ifndef SYNTHESIS
    rvalid_without_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni || clr_i) !(rvalid && (outstanding_q == '0))
    );
`endif

endmodule

// File: tb/tb_output_memory_node.sv
// Randomized scoreboard bench for output_memory_node: an OBI slave model with random grant and
// response latency, an ODM driver, and a monitor checking writes, back-pressure and completion.
module tb_output_memory_node;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        exec = 1'b0;
    logic [31:0] addr_base = 32'h0;
    logic [15:0] size = 16'h0;
    logic [15:0] stride = 16'h4;
    logic [69:0] req_bus;
    logic [33:0] resp_bus;
    logic [31:0] din = 32'h0;
    logic        din_v = 1'b0;
    logic        din_r;
    logic        done;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;

    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;

    assign {m_req, m_we, m_be, m_addr, m_wdata} = req_bus;
    assign resp_bus = {gnt, rvalid, 32'hdead_beef};

    output_memory_node #(
        .FIFO_DEPTH     (DEPTH),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clr_i          (clr),
        .exec_i         (exec),
        .output_addr_i  (addr_base),
        .output_size_i  (size),
        .output_stride_i(stride),
        .masters_req_o  (req_bus),
        .masters_resp_i (resp_bus),
        .din_i          (din),
        .din_v_i        (din_v),
        .din_r_o        (din_r),
        .done_o         (done)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          n_exp = 0;
    int          written = 0;
    int          accepted = 0;
    int          pending = 0;
    int          last_rv = 0;
    bit          done_seen = 1'b0;
    bit          checking = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_wdata;

    // slave knobs
    int gnt_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    int hold_until = 0;
    int rsp_due[$];

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int num_writes(input int sz, input int st);
        return (sz == 0) ? 0 : (sz + st - 1) / st;
    endfunction

    // ---------------- OBI slave model ----------------
    always @(posedge clk) begin
        #1;
        gnt    = 1'b0;
        rvalid = 1'b0;
        if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
            rvalid = 1'b1;
            void'(rsp_due.pop_front());
        end
        if (m_req && cyc >= hold_until && int'($urandom_range(99, 0)) < gnt_pct) begin
            gnt = 1'b1;
            rsp_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic        exp_dr;
        logic [63:0] e;
        if (checking) begin
            if (prev_stall) begin
                chk(m_req && m_addr == prev_addr && m_wdata == prev_wdata, "obi_hold",
                    {m_addr, m_wdata}, {prev_addr, prev_wdata});
            end
            if (m_req) begin
                chk(m_we && m_be == 4'hf, "obi_fixed", {59'h0, m_we, m_be}, 64'h1f);
                chk(pending < MAXO, "max_outstanding", 64'(pending), 64'(MAXO));
                chk(written < n_exp, "req_beyond_size", 64'(written), 64'(n_exp));
            end
            exp_dr = (written >= n_exp) ? exec : (exec && (accepted - written) < DEPTH);
            chk(din_r == exp_dr, "din_ready", 64'(din_r), 64'(exp_dr));
            if (m_req && gnt) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "write_unexpected", {m_addr, m_wdata}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk({m_addr, m_wdata} == e, "write_addr_data", {m_addr, m_wdata}, e);
                end
            end
            if (done_seen) begin
                chk(done, "done_sticky", 64'(done), 64'h1);
            end else if (done) begin
                done_seen = 1'b1;
                chk(written == n_exp && pending == 0 && exp_q.size() == 0, "done_early",
                    64'(written), 64'(n_exp));
                if (n_exp > 0) chk(cyc == last_rv + 2, "done_timing", 64'(cyc), 64'(last_rv + 2));
            end
            if (din_v && din_r && written < n_exp) begin
                if (accepted < n_exp) begin
                    exp_q.push_back({addr_base + 32'(accepted) * 32'(stride), din});
                end
                accepted++;
            end
            if (m_req && gnt) begin
                written++;
                pending++;
            end
            if (rvalid) begin
                pending--;
                last_rv = cyc;
            end
            prev_stall = m_req && !gnt;
            prev_addr  = m_addr;
            prev_wdata = m_wdata;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic prep(input logic [31:0] base, input int sz, input int st, input int gpct,
                        input int lmin, input int lmax, input int hold);
        @(posedge clk); #2;
        checking = 1'b0;
        clr      = 1'b1;
        exec     = 1'b0;
        din_v    = 1'b0;
        @(posedge clk); #2;
        clr        = 1'b0;
        exp_q.delete();
        written    = 0;
        accepted   = 0;
        pending    = 0;
        last_rv    = 0;
        done_seen  = 1'b0;
        prev_stall = 1'b0;
        addr_base  = base;
        size       = 16'(sz);
        stride     = 16'(st);
        n_exp      = num_writes(sz, st);
        gnt_pct    = gpct;
        lat_min    = lmin;
        lat_max    = lmax;
        hold_until = cyc + hold;
        assert (!(sz != 0 && st == 0)) else $error("stride 0 with nonzero size never terminates");
        checking = 1'b1;
        exec     = 1'b1;
    endtask

    task automatic send_words(input int n, input int vpct);
        for (int i = 0; i < n; i++) begin
            bit hs;
            int guard;
            while (int'($urandom_range(99, 0)) >= vpct) begin
                din_v = 1'b0;
                @(posedge clk); #2;
            end
            din_v = 1'b1;
            din   = $urandom;
            hs    = 1'b0;
            guard = 0;
            while (!hs && guard < 1000) begin
                @(negedge clk);
                hs = din_r;
                @(posedge clk); #2;
                guard++;
            end
            if (!hs) begin
                chk(1'b0, "din_accept_timeout", 64'(i), 64'(n));
                break;
            end
        end
        din_v = 1'b0;
    endtask

    task automatic finish_test();
        int t = 0;
        while (!done_seen && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk(done_seen, "done_timeout", 64'(done_seen), 64'h1);
        repeat (3) @(posedge clk);
        #2;
        chk(exp_q.size() == 0, "all_written", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic run_test(input logic [31:0] base, input int sz, input int st, input int nwords,
                            input int gpct, input int lmin, input int lmax, input int hold,
                            input int vpct);
        prep(base, sz, st, gpct, lmin, lmax, hold);
        if (sz == 0) begin
            @(negedge clk);
            chk(!done, "size0_done_early", 64'(done), 64'h0);
            @(negedge clk);
            chk(done, "size0_done_next", 64'(done), 64'h1);
        end
        send_words(nwords, vpct);
        finish_test();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk(!m_req, "reset_req", 64'(m_req), 64'h0);
        chk(!done, "reset_done", 64'(done), 64'h0);
        chk(!din_r, "reset_din_r", 64'(din_r), 64'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk(!m_req && !done && !din_r, "post_reset_idle", {61'h0, m_req, done, din_r}, 64'h0);

        run_test(32'h0000_1000, 16, 4, 4, 100, 1, 1, 0, 100);   // basic stream
        run_test(32'h0000_2000, 0, 4, 0, 100, 1, 1, 0, 100);    // size 0
        run_test(32'h0000_3000, 32, 4, 8, 100, 1, 1, 10, 100);  // grant stall, FIFO fills
        run_test(32'h0000_4000, 24, 4, 6, 100, 5, 5, 0, 100);   // slow responses
        run_test(32'h0000_5000, 8, 4, 3, 100, 1, 1, 0, 100);    // extra word discarded

        // clear while two words are buffered and nothing was granted
        prep(32'h0000_1000, 16, 4, 100, 1, 1, 100000);
        send_words(2, 100);
        repeat (2) @(posedge clk);
        #2;
        checking = 1'b0;
        clr      = 1'b1;
        exec     = 1'b0;
        @(posedge clk); #2;
        clr = 1'b0;
        @(negedge clk);
        chk(!m_req, "clr_req", 64'(m_req), 64'h0);
        chk(!done, "clr_done", 64'(done), 64'h0);
        chk(!din_r, "clr_din_r", 64'(din_r), 64'h0);
        run_test(32'h0000_1000, 16, 4, 4, 100, 1, 1, 0, 100);

        run_test(32'hFFFF_FFF8, 16, 4, 5, 70, 1, 3, 0, 80);     // address wrap
        run_test(32'h0000_6000, 10, 4, 4, 60, 1, 4, 0, 60);     // size not a stride multiple

        for (int k = 0; k < 8; k++) begin
            int st, sz, n;
            st = int'($urandom_range(12, 1));
            sz = int'($urandom_range(48, 1));
            n  = num_writes(sz, st) + int'($urandom_range(3, 0));
            run_test($urandom, sz, st, n, int'($urandom_range(100, 30)), 1,
                     int'($urandom_range(6, 1)), int'($urandom_range(6, 0)),
                     int'($urandom_range(100, 40)));
        end

        @(posedge clk); #2;
        checking = 1'b0;
        exec     = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
